// File: rtl/maxterm_pkg.sv
// Shared definitions for the maxterm extractor: state encoding,
// default sizing and the count-width helper.
package maxterm_pkg;

  // Default number of inputs of the function under test.
  localparam int DEF_N_VARS = 4;

  // Truth-table size for the default input count.
  localparam int TT = 2 ** DEF_N_VARS;

  // Width of the settle counter; covers SETTLE values 1..15.
  localparam int SETTLE_W = 4;

  // Scan state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_EMIT = ST_EMIT,
    S_DONE = ST_DONE
  } state_t;

  // The maxterm count can reach 2**n_vars, which needs n_vars+1 bits.
  function automatic int count_width(input int n_vars);
    return n_vars + 1;
  endfunction

endpackage

// File: rtl/maxterm_extractor_settle_timer.sv
// Load/decrement counter that marks the last cycle of the settle window.
module settle_timer
  import maxterm_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE);
  localparam logic [SETTLE_W-1:0] ONE      = SETTLE_W'(1);

  logic [SETTLE_W-1:0] cnt_q;
  logic [SETTLE_W-1:0] cnt_d;

  // Reload wins over decrement; the count never goes below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of one means the current cycle is the last settle cycle.
  assign expired = (cnt_q == ONE);

endmodule

// File: rtl/maxterm_extractor.sv
// Walks every input combination of an external function, samples its
// output after a settle window and streams out each index where it is 0.
module maxterm_extractor
  import maxterm_pkg::*;
#(
  parameter int N_VARS = DEF_N_VARS,
  parameter int SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        f_in,
  output logic [N_VARS-1:0]           stim,
  output logic                        busy,
  output logic                        done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_VARS-1:0]           out_idx,
  output logic [(1<<N_VARS)-1:0]      maxterm_mask,
  output logic [count_width(N_VARS)-1:0] maxterm_count
);

  localparam int NUM_ROWS = 1 << N_VARS;
  localparam int CW       = count_width(N_VARS);

  localparam logic [N_VARS-1:0] IDX_LAST = '1;
  localparam logic [N_VARS-1:0] IDX_ONE  = N_VARS'(1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);

  state_t                state_q, state_d;
  logic [N_VARS-1:0]     idx_q, idx_d;
  logic [NUM_ROWS-1:0]   mask_q, mask_d;
  logic [CW-1:0]         count_q, count_d;
  logic [N_VARS-1:0]     out_idx_q, out_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  tmr_load;
  logic                  tmr_dec;
  logic                  tmr_expired;
  logic                  advance;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .dec     (tmr_dec),
    .expired (tmr_expired)
  );

  // Next-state logic; advance folds the index step into the edge that
  // finishes a sample or an emit, so no separate advance cycle exists.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    count_d     = count_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d   = '0;
          count_d  = '0;
          idx_d    = '0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tmr_expired) begin
          if (!f_in) begin
            mask_d[idx_q] = 1'b1;
            count_d       = count_q + CNT_ONE;
            out_idx_d     = idx_q;
            out_valid_d   = 1'b1;
            state_d       = S_EMIT;
          end else begin
            advance = 1'b1;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          advance     = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Terminal check comes before the increment so idx never wraps.
    if (advance) begin
      if (idx_q == IDX_LAST) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        idx_d    = idx_q + IDX_ONE;
        tmr_load = 1'b1;
        state_d  = S_WAIT;
      end
    end
  end

  // State and datapath registers; reset aborts any scan immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mask_q      <= '0;
      count_q     <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign stim          = idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign out_valid     = out_valid_q;
  assign out_idx       = out_idx_q;
  assign maxterm_mask  = mask_q;
  assign maxterm_count = count_q;

endmodule

// File: tb/tb_maxterm_extractor.sv
// Directed and randomized checks of maxterm_extractor. Two instances run
// side by side: one with SETTLE=1 and one with SETTLE=3 whose f_in is
// forced low during the first two cycles of every settle window.
module tb_maxterm_extractor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ready1 = 1'b0;
  logic        ready3 = 1'b1;
  logic        f_in1, f_in3;
  int          f_sel = 0;
  logic [15:0] rnd_tt = 16'h0;

  logic [3:0]  stim1, stim3, out_idx1, out_idx3;
  logic        busy1, busy3, done1, done3, out_valid1, out_valid3;
  logic [15:0] mask1, mask3;
  logic [4:0]  count1, count3;

  int total = 0;
  int bad   = 0;

  // dut3 settle tracking
  int          age3 = 0;
  logic [3:0]  last_stim3 = 4'h0;
  logic        last_busy3 = 1'b0;

  always #5 clk = ~clk;

  maxterm_extractor #(.N_VARS(4), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .f_in(f_in1), .stim(stim1),
    .busy(busy1), .done(done1), .out_valid(out_valid1), .out_ready(ready1),
    .out_idx(out_idx1), .maxterm_mask(mask1), .maxterm_count(count1)
  );

  maxterm_extractor #(.N_VARS(4), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .f_in(f_in3), .stim(stim3),
    .busy(busy3), .done(done3), .out_valid(out_valid3), .out_ready(ready3),
    .out_idx(out_idx3), .maxterm_mask(mask3), .maxterm_count(count3)
  );

  // Function under test selected by sel: 0 = reference sum of maxterms,
  // 1 = constant 1, 2 = constant 0, otherwise a random truth table.
  function automatic logic f_eval(input int sel, input logic [15:0] tt, input logic [3:0] x);
    logic a, b, c, d;
    {a, b, c, d} = x;
    case (sel)
      0:       return (c | d) & (b | c | ~a) & (~b | ~c | ~d) & (b | ~c | d);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return tt[x];
    endcase
  endfunction

  assign f_in1 = f_eval(f_sel, rnd_tt, stim1);
  assign f_in3 = (age3 < 2) ? 1'b0 : f_eval(f_sel, rnd_tt, stim3);

  // Count cycles since dut3 started on a new index (stim change or scan start).
  always @(negedge clk) begin
    if ((stim3 != last_stim3) || (busy3 && !last_busy3)) age3 <= 0;
    else if (age3 < 15) age3 <= age3 + 1;
    last_stim3 <= stim3;
    last_busy3 <= busy3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full scan on both instances. stall_len < 0 picks a random stall
  // per emitted index; poke_start pulses start while the scan is busy.
  task automatic run_scan(input int sel, input int stall_len, input bit poke_start,
                          input string nm, output int d1_at);
    int exp_q[$];
    int got1[$];
    int got3[$];
    logic [15:0] exp_mask;
    int m, stall_total, done1_at, done3_at, done1_n, done3_n, remaining, cyc, last_at;
    bit holding;
    logic [3:0] hold_idx, hold_stim;

    f_sel = sel;
    exp_mask = 16'h0;
    for (int i = 0; i < 16; i++) begin
      if (!f_eval(sel, rnd_tt, 4'(i))) begin
        exp_q.push_back(i);
        exp_mask[i] = 1'b1;
      end
    end
    m = exp_q.size();
    stall_total = 0; holding = 0; remaining = 0;
    done1_at = 0; done3_at = 0; done1_n = 0; done3_n = 0;
    hold_idx = 4'h0; hold_stim = 4'h0;

    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({nm, "_busy_after_start"}, {31'd0, busy1}, 32'd1);
    while (cyc < 2000) begin
      start = (poke_start && (cyc == 4 || cyc == 11)) ? 1'b1 : 1'b0;
      if (out_valid1) begin
        if (!holding) begin
          holding   = 1'b1;
          hold_idx  = out_idx1;
          hold_stim = stim1;
          got1.push_back(int'(out_idx1));
          remaining = (stall_len < 0) ? int'($urandom_range(0, 3)) : stall_len;
          stall_total += remaining;
        end else begin
          chk({nm, "_stall_idx"}, {28'd0, out_idx1}, {28'd0, hold_idx});
          chk({nm, "_stall_stim"}, {28'd0, stim1}, {28'd0, hold_stim});
        end
        ready1 = (remaining == 0);
        if (remaining == 0) holding = 1'b0;
        else remaining--;
      end else begin
        ready1 = 1'($urandom_range(0, 1));
      end
      if (out_valid3) got3.push_back(int'(out_idx3));
      if (done1) begin
        done1_n++;
        if (done1_n == 1) begin
          done1_at = cyc;
          chk({nm, "_busy_at_done"}, {31'd0, busy1}, 32'd0);
        end
      end
      if (done3) begin
        done3_n++;
        if (done3_n == 1) done3_at = cyc;
      end
      last_at = (done1_at > done3_at) ? done1_at : done3_at;
      if (done1_n > 0 && done3_n > 0 && cyc >= last_at + 2) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    chk({nm, "_done1_pulses"}, done1_n, 1);
    chk({nm, "_done3_pulses"}, done3_n, 1);
    chk({nm, "_n_idx1"}, got1.size(), m);
    chk({nm, "_n_idx3"}, got3.size(), m);
    for (int i = 0; i < m; i++) begin
      if (i < got1.size()) chk({nm, $sformatf("_idx1_%0d", i)}, got1[i], exp_q[i]);
      if (i < got3.size()) chk({nm, $sformatf("_idx3_%0d", i)}, got3[i], exp_q[i]);
    end
    chk({nm, "_mask1"}, {16'd0, mask1}, {16'd0, exp_mask});
    chk({nm, "_mask3"}, {16'd0, mask3}, {16'd0, exp_mask});
    chk({nm, "_count1"}, {27'd0, count1}, m);
    chk({nm, "_count3"}, {27'd0, count3}, m);
    chk({nm, "_done1_cycle"}, done1_at, 16 * 1 + m + 1 + stall_total);
    chk({nm, "_done3_cycle"}, done3_at, 16 * 3 + m + 1);
    $display("scan %s: maxterms=%0d mask=%04h done1@%0d done3@%0d", nm, m, mask1, done1_at, done3_at);
    d1_at = done1_at;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_stim"},  {28'd0, stim1}, 32'd0);
    chk({nm, "_busy"},  {31'd0, busy1}, 32'd0);
    chk({nm, "_done"},  {31'd0, done1}, 32'd0);
    chk({nm, "_valid"}, {31'd0, out_valid1}, 32'd0);
    chk({nm, "_idx"},   {28'd0, out_idx1}, 32'd0);
    chk({nm, "_mask"},  {16'd0, mask1}, 32'd0);
    chk({nm, "_count"}, {27'd0, count1}, 32'd0);
    chk({nm, "_mask3"}, {16'd0, mask3}, 32'd0);
    chk({nm, "_busy3"}, {31'd0, busy3}, 32'd0);
  endtask

  initial begin
    int d1;
    int seen_done;

    // Power-on reset
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Reference function, no back-pressure
    run_scan(0, 0, 1'b0, "func", d1);
    chk("func_done_lit", d1, 26);
    chk("func_mask_lit", {16'd0, mask1}, 32'h9795);
    chk("func_count_lit", {27'd0, count1}, 32'd9);

    // Constant functions
    run_scan(1, 0, 1'b0, "const1", d1);
    chk("const1_done_lit", d1, 17);
    run_scan(2, 0, 1'b0, "const0", d1);
    chk("const0_mask_lit", {16'd0, mask1}, 32'hFFFF);

    // Five-cycle stall at every valid
    run_scan(0, 5, 1'b0, "stall", d1);
    chk("stall_done_lit", d1, 71);

    // start pulses while busy must be ignored
    run_scan(0, 0, 1'b1, "poke", d1);
    chk("poke_done_lit", d1, 26);

    // Asynchronous reset in the middle of a scan
    f_sel = 0;
    ready1 = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && stim1 != 4'd6; k++) @(negedge clk);
    chk("midrst_reach_idx6", {28'd0, stim1}, 32'd6);
    #2 reset = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done1 || busy1) seen_done++;
    end
    chk("midrst_no_done", seen_done, 0);
    run_scan(0, 0, 1'b0, "rescan", d1);
    chk("rescan_done_lit", d1, 26);

    // Random truth tables with random back-pressure
    for (int r = 0; r < 4; r++) begin
      rnd_tt = 16'($urandom);
      run_scan(3, -1, 1'b0, $sformatf("rand%0d", r), d1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxterm_extractor.md
Name: maxterm_extractor

Overview:
- Sequential inverse of the team's maxterm evaluators: scans every input combination of an external combinational function under test, samples its output, and records each index where the output is 0.
- Drives the function's inputs from `stim`, builds a maxterm bitmask and a count, and streams each maxterm index out over a valid/ready handshake.
- Sits beside truth-table benches and logic-minimisation exercises as a hardware truth-table reader.

Parameters:
- N_VARS, 4, number of function inputs; table size TT = 2**N_VARS.
- SETTLE, 1, cycles `stim` is held stable before `f_in` is sampled; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- f_in  in  1  output of the function under test.
- stim  out  N_VARS  input combination driven to the function; msb = first variable (a).
- busy  out  1  high from the edge that accepts start until DONE is entered.
- done  out  1  one-cycle pulse at the end of a scan.
- out_valid  out  1  maxterm index available.
- out_ready  in  1  consumer accepts the index.
- out_idx  out  N_VARS  current maxterm index.
- maxterm_mask  out  TT  bit i = 1 iff f(i) = 0.
- maxterm_count  out  N_VARS+1  number of maxterms found.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, index 0. Reset mid-scan aborts immediately; no done pulse is produced.
- IDLE: start=1 at an edge clears mask and count, sets idx=0, stim=0, busy=1, settle counter=SETTLE, and moves to WAIT. start is ignored in every other state.
- WAIT: stim=idx is held. The counter decrements each cycle. `f_in` is sampled at the edge that ends the SETTLE-th WAIT cycle; `f_in` values in earlier cycles are ignored.
- Sample, f_in=0: set mask[idx], count+1, out_idx=idx, out_valid=1, go to EMIT.
- Sample, f_in=1: go to ADVANCE (same edge, no extra cycle).
- EMIT: out_valid and out_idx are held stable until an edge with out_ready=1. At that edge out_valid drops and the advance is taken. out_ready low stalls indefinitely with stim unchanged. Minimum EMIT residency is 1 cycle (no combinational ready→valid path).
- ADVANCE rule:
  - If idx = TT-1, go to DONE.
  - Otherwise idx+1, stim=idx+1, reload the counter, go to WAIT.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. Mask and count hold until the next accepted start.
- Latency with out_ready tied to 1: done is high in cycle TT*SETTLE + M + 1 after the start edge, where M is the maxterm count.
- Width rules:
  - count saturates naturally; its maximum is TT, which fits in N_VARS+1 bits.
  - idx never wraps; the terminal index check precedes the increment.
- start held high continuously: a new scan begins on the edge after DONE, i.e. in IDLE.

Decomposition:
- Package maxterm_pkg holds:
  - the state encoding (IDLE, WAIT, EMIT, DONE) as localparams;
  - the default N_VARS;
  - TT;
  - the width function for the count.
- One natural sub-module, settle_timer: a load/decrement counter with an expired flag, parameterised by SETTLE.
- The index register, mask and FSM stay in the top level.

Test Plan:
- Function f = (c|d)&(b|c|~a)&(~b|~c|~d)&(b|~c|d), with inputs a..d = stim[3:0], SETTLE=1, out_ready=1 → out_idx sequence 0,2,4,7,8,9,10,12,15; mask=16'h9795; count=9; done pulse in cycle 26 after start.
- f constant 1 → no out_valid; mask=0; count=0; done in cycle 17. f constant 0 → 16 indices 0..15; mask=16'hFFFF; count=16.
- Same function as scenario 1, out_ready low for 5 cycles at each valid → out_idx/out_valid stable while stalled, stim frozen, identical mask; done delayed by 45 cycles.
- SETTLE=3, f_in forced to 0 during the first two WAIT cycles of each index, true value on the third → result identical to scenario 1 (only the last-cycle sample counts).
- reset asserted asynchronously mid-scan at idx=6, then start pulsed again → outputs 0 immediately without a clock edge, no done pulse; the rescan gives the correct full result. start pulses while busy → ignored, no restart.
